// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// One radix-2 step per cycle; multiply (shift-add) and divide (restoring)
// share one adder and one 2*WIDTH shift register.
// Optional feature macro: MDU_SIGNED_EN. When defined, op[0] selects signed
// MULT/DIV. When undefined, every operation is unsigned and the sign
// correction hardware is absent.
//
// state  | meaning
// S_IDLE | waiting; accepts start or MTHI/MTLO writes
// S_RUN  | WIDTH radix-2 iterations, counter counts down to terminal 1
// S_FIX  | sign correction, hi/lo written at the edge leaving this state
module mdu_iterative #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_we_hi,
    input  logic             i_we_lo,
    input  logic [WIDTH-1:0] i_wd,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]     r_mb;
    logic                 r_div;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_dz;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_opa;
    logic [WIDTH:0]       w_opb;
    logic [WIDTH+1:0]     w_sum;
    logic [2*WIDTH-1:0]   w_p_step;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Divide by zero: restoring division with a zero divisor naturally leaves
    // the dividend in the remainder and all ones in the quotient, so the raw
    // dividend is latched and no sign correction is applied.
    assign w_dz = i_op[1] & (i_b == '0);

`ifdef MDU_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_a_neg = i_op[0] & i_a[WIDTH-1];
    assign w_b_neg = i_op[0] & i_b[WIDTH-1];
    assign w_mag_a = (w_a_neg && !w_dz) ? -i_a : i_a;
    assign w_mag_b = w_b_neg ? -i_b : i_b;

    // Record result signs at start; quotient/product sign and remainder sign
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_neg_q <= (w_a_neg ^ w_b_neg) & ~w_dz;
            r_neg_r <= w_a_neg & ~w_dz;
        end
    end

    assign w_prod_fix = r_neg_q ? -r_p : r_p;
    assign w_res_hi = r_div ? (r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH])
                            : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_div ? (r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0])
                            : w_prod_fix[WIDTH-1:0];
`else
    logic w_unused_op0;

    assign w_unused_op0 = i_op[0];
    assign w_mag_a  = i_a;
    assign w_mag_b  = i_b;
    assign w_res_hi = r_p[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_p[WIDTH-1:0];
`endif

    // Shared adder: add for multiply, subtract (trial) for divide.
    // Divide operand is the upper half already shifted left by one.
    assign w_opa = r_div ? r_p[2*WIDTH-1:WIDTH-1] : {1'b0, r_p[2*WIDTH-1:WIDTH]};
    assign w_opb = {1'b0, r_mb};
    assign w_sum = {1'b0, w_opa} + (r_div ? ~{1'b0, w_opb} : {1'b0, w_opb})
                 + {{(WIDTH+1){1'b0}}, r_div};

    // One radix-2 iteration of the shift register
    always_comb begin
        w_p_step = r_p;
        if (r_div) begin
            if (!w_sum[WIDTH+1])
                w_p_step = {w_sum[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
            else
                w_p_step = {r_p[2*WIDTH-2:0], 1'b0};
        end else if (r_p[0]) begin
            w_p_step = {w_sum[WIDTH:0], r_p[WIDTH-1:1]};
        end else begin
            w_p_step = {1'b0, r_p[2*WIDTH-1:1]};
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result write and MTHI/MTLO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_p    <= '0;
            r_mb   <= '0;
            r_div  <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_p   <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mb  <= w_mag_b;
                        r_div <= i_op[1];
                        r_cnt <= CNT_W'(WIDTH);
                    end else begin
                        if (i_we_hi) r_hi <= i_wd;
                        if (i_we_lo) r_lo <= i_wd;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative (WIDTH=32); expectations follow the
// MDU_SIGNED_EN setting of the build.
module tb_mdu_iterative;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_bad   = 0;

    mdu_iterative #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_we_hi (we_hi),
        .i_we_lo (we_lo),
        .i_wd    (wd),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Start one operation, wait (bounded) for done, check latency and result
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        logic [31:0] old_lo;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        old_lo = lo;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1 || n == 32) check_val({tag, "_busy"}, 32'(busy), 32'd1);
            if (n == 16) check_val({tag, "_lo_hold"}, lo, old_lo);
        end
        check_val({tag, "_lat"}, n, 32'd33);
        check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_val({tag, "_hi"}, hi, ehi);
        check_val({tag, "_lo"}, lo, elo);
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        we_hi = 1'b0; we_lo = 1'b0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("divu_dz", 2'b10, 32'h64, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF);
        do_op("div_dz_neg", 2'b11, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
`ifdef MDU_SIGNED_EN
        do_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("mult_7xm2", 2'b01, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        do_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
        do_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
        do_op("mult_7xm2", 2'b01, 32'd7, 32'hFFFF_FFFE, 32'h0000_0006, 32'hFFFF_FFF2);
        do_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        do_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000);
        do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
`endif

        // MTHI/MTLO: both together, then hi alone
        @(negedge clk);
        we_hi = 1'b1; we_lo = 1'b1; wd = 32'hA5;
        @(negedge clk);
        we_lo = 1'b0; wd = 32'h11;
        @(negedge clk);
        we_hi = 1'b0;
        check_val("mt_hi", hi, 32'h11);
        check_val("mt_lo", lo, 32'hA5);

        // DIVU 9/4 with a simultaneous dropped write, a late start and a late MTLO
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd4; we_lo = 1'b1; wd = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; we_lo = 1'b0;
        check_val("sw_lo_drop", lo, 32'hA5);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            start = (n == 4);
            if (n == 4) begin a = 32'd100; b = 32'd3; end
            we_lo = (n == 5);
            wd = 32'h77;
            @(posedge clk); #1;
            n++;
            if (n == 7) check_val("busy_lo_hold", lo, 32'hA5);
            if (n == 7) check_val("busy_hi_hold", hi, 32'h11);
        end
        start = 1'b0; we_lo = 1'b0;
        check_val("d94_lat", n, 32'd33);
        check_val("d94_hi", hi, 32'd1);
        check_val("d94_lo", lo, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check_val("no_queue_busy", 32'(busy), 32'd0);

        // Reset in the middle of a MULTU
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_hi", hi, 32'd0);
        check_val("abort_lo", lo, 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_val("abort_no_done", pulses, 32'd0);
        check_val("abort_hi_after", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
